sf_frame_sequencer: RTL and testbench

Controller that sequences the smoothing-filter datapath for one ADC frame. On `start` it captures `FRAME_LEN` ADC samples into an external single-port sample RAM. It then re-reads the RAM to compute a sliding-window moving average of width `WIN` with a running sum, and streams the results out over a valid/ready interface. It sits between the ADC sample stream and the result sink, and replaces whole-array software-style filtering with a cycle-accurate, backpressure-aware schedule.

---
 rtl/sf_frame_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_sf_frame_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sf_frame_sequencer.sv
// Frame sequencer for the smoothing filter: captures one ADC frame into an external RAM,
// then streams a WIN-wide moving average. Define SF_SEQ_ROUND_EN for round-half-up averages.
module sf_frame_sequencer #(
   parameter int DATA_W    = 8,
   parameter int OUT_W     = 16,
   parameter int ADDR_W    = 10,
   parameter int WIN       = 51,
   parameter int FRAME_LEN = 1000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   input  logic              adc_valid_i,
   output logic              adc_ready_o,
   input  logic [DATA_W-1:0] adc_data_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [OUT_W-1:0]  out_data_o,
   output logic [ADDR_W-1:0] out_index_o
);

   // WIN <= 2**clog2(WIN), so a full window of max-scale samples always fits in SUM_W bits
   localparam int SUM_W = DATA_W + $clog2(WIN);
   localparam int DIV_W = SUM_W + 1;
   localparam int CNT_W = ADDR_W + 1;

   localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0]  WIN_CNT     = CNT_W'(WIN);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
   localparam logic [ADDR_W-1:0] LAST_K      = ADDR_W'(FRAME_LEN - WIN);
   localparam logic [ADDR_W-1:0] WIN_M1      = ADDR_W'(WIN - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
   localparam logic [DIV_W-1:0]  WIN_DIV     = DIV_W'(WIN);
   localparam logic [DIV_W-1:0]  HALF_WIN    = DIV_W'(WIN / 2);

   typedef enum logic [2:0] {
      S_IDLE, S_CAPTURE, S_PRIME, S_RUN_NEW, S_RUN_ADD, S_OUT, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [OUT_W-1:0]  out_data_q, out_data_d;
   logic [ADDR_W-1:0] out_index_q, out_index_d;
   logic [SUM_W-1:0]  rd_ext;
   logic [SUM_W-1:0]  sum_add;
   logic [SUM_W-1:0]  sum_sub;

   function automatic logic [OUT_W-1:0] avg_f(input logic [SUM_W-1:0] s);
      logic [DIV_W-1:0] num;
`ifdef SF_SEQ_ROUND_EN
      num = {1'b0, s} + HALF_WIN;
`else
      num = {1'b0, s};
`endif
      return OUT_W'(num / WIN_DIV);
   endfunction

   assign rd_ext  = SUM_W'(mem_rdata_i);
   assign sum_add = sum_q + rd_ext;
   assign sum_sub = sum_q - rd_ext;

   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
   assign adc_ready_o = (state_q == S_CAPTURE);
   assign out_valid_o = (state_q == S_OUT);
   assign out_data_o  = out_data_q;
   assign out_index_o = out_index_q;

   // State and datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         sum_q       <= {SUM_W{1'b0}};
         out_data_q  <= {OUT_W{1'b0}};
         out_index_q <= {ADDR_W{1'b0}};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
      end
   end

   // Next-state, RAM port and running-sum control
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      mem_we_o    = 1'b0;
      mem_addr_o  = {ADDR_W{1'b0}};
      mem_wdata_o = {DATA_W{1'b0}};
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_CAPTURE;
               cnt_d   = {CNT_W{1'b0}};
               sum_d   = {SUM_W{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CAPTURE: begin
            if (adc_valid_i) begin
               mem_we_o    = 1'b1;
               mem_addr_o  = cnt_q[ADDR_W-1:0];
               mem_wdata_o = adc_data_i;
               if (cnt_q == LAST_SAMPLE) begin
                  cnt_d   = {CNT_W{1'b0}};
                  state_d = S_PRIME;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_PRIME: begin
            // Reads lead the adds by one cycle; cnt_q==0 has no data back yet
            if (cnt_q < WIN_CNT) begin
               mem_addr_o = cnt_q[ADDR_W-1:0];
            end else begin
               mem_addr_o = {ADDR_W{1'b0}};
            end
            if (cnt_q != {CNT_W{1'b0}}) begin
               sum_d = sum_add;
            end else begin
               sum_d = sum_q;
            end
            if (cnt_q == WIN_CNT) begin
               out_data_d  = avg_f(sum_add);
               out_index_d = {ADDR_W{1'b0}};
               state_d     = S_OUT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_OUT: begin
            // The accept cycle doubles as the old-sample read for the next window
            if (out_ready_i) begin
               if (out_index_q == LAST_K) begin
                  state_d = S_DONE;
               end else begin
                  mem_addr_o  = out_index_q;
                  out_index_d = out_index_q + ADDR_ONE;
                  state_d     = S_RUN_NEW;
               end
            end else begin
               state_d = S_OUT;
            end
         end
         S_RUN_NEW: begin
            mem_addr_o = out_index_q + WIN_M1;
            sum_d      = sum_sub;
            state_d    = S_RUN_ADD;
         end
         S_RUN_ADD: begin
            sum_d      = sum_add;
            out_data_d = avg_f(sum_add);
            state_d    = S_OUT;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sf_frame_sequencer.sv
// Randomized self-checking bench for sf_frame_sequencer: a small (WIN=4, FRAME_LEN=8) and a
// default-size instance, each with a 1-cycle-latency RAM, checked against a window-sum model.
module tb_sf_frame_sequencer;

   localparam int DW    = 8;
   localparam int OW    = 16;
   localparam int AW    = 10;
   localparam int WIN_S = 4;
   localparam int FL_S  = 8;
   localparam int WIN_D = 51;
   localparam int FL_D  = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          start, adc_valid, out_ready;
   logic [DW-1:0] adc_data;
   logic          sel;
   logic          s_start, d_start;
   assign s_start = start & ~sel;
   assign d_start = start & sel;

   logic          s_busy, s_done, s_adc_ready, s_mem_we, s_out_valid;
   logic [AW-1:0] s_mem_addr, s_out_index;
   logic [DW-1:0] s_mem_wdata, s_mem_rdata;
   logic [OW-1:0] s_out_data;
   logic          d_busy, d_done, d_adc_ready, d_mem_we, d_out_valid;
   logic [AW-1:0] d_mem_addr, d_out_index;
   logic [DW-1:0] d_mem_wdata, d_mem_rdata;
   logic [OW-1:0] d_out_data;

   logic [DW-1:0] s_ram [0:(1<<AW)-1];
   logic [DW-1:0] d_ram [0:(1<<AW)-1];

   logic          m_busy, m_done, m_adc_ready, m_mem_we, m_out_valid;
   logic [AW-1:0] m_mem_addr, m_out_index;
   logic [DW-1:0] m_mem_wdata;
   logic [OW-1:0] m_out_data;
   assign m_busy      = sel ? d_busy      : s_busy;
   assign m_done      = sel ? d_done      : s_done;
   assign m_adc_ready = sel ? d_adc_ready : s_adc_ready;
   assign m_mem_we    = sel ? d_mem_we    : s_mem_we;
   assign m_mem_addr  = sel ? d_mem_addr  : s_mem_addr;
   assign m_mem_wdata = sel ? d_mem_wdata : s_mem_wdata;
   assign m_out_valid = sel ? d_out_valid : s_out_valid;
   assign m_out_data  = sel ? d_out_data  : s_out_data;
   assign m_out_index = sel ? d_out_index : s_out_index;

   sf_frame_sequencer #(.DATA_W(DW), .OUT_W(OW), .ADDR_W(AW), .WIN(WIN_S), .FRAME_LEN(FL_S)) u_small (
      .clk_i(clk), .rst_i(rst), .start_i(s_start), .busy_o(s_busy), .done_o(s_done),
      .adc_valid_i(adc_valid), .adc_ready_o(s_adc_ready), .adc_data_i(adc_data),
      .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata), .mem_rdata_i(s_mem_rdata),
      .out_valid_o(s_out_valid), .out_ready_i(out_ready), .out_data_o(s_out_data), .out_index_o(s_out_index)
   );

   sf_frame_sequencer #(.DATA_W(DW), .OUT_W(OW), .ADDR_W(AW), .WIN(WIN_D), .FRAME_LEN(FL_D)) u_dflt (
      .clk_i(clk), .rst_i(rst), .start_i(d_start), .busy_o(d_busy), .done_o(d_done),
      .adc_valid_i(adc_valid), .adc_ready_o(d_adc_ready), .adc_data_i(adc_data),
      .mem_we_o(d_mem_we), .mem_addr_o(d_mem_addr), .mem_wdata_o(d_mem_wdata), .mem_rdata_i(d_mem_rdata),
      .out_valid_o(d_out_valid), .out_ready_i(out_ready), .out_data_o(d_out_data), .out_index_o(d_out_index)
   );

   always @(posedge clk) begin
      if (s_mem_we) s_ram[s_mem_addr] <= s_mem_wdata;
      s_mem_rdata <= s_ram[s_mem_addr];
      if (d_mem_we) d_ram[d_mem_addr] <= d_mem_wdata;
      d_mem_rdata <= d_ram[d_mem_addr];
   end

   int n_checks = 0;
   int n_fail   = 0;
   int model_q[$];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Average of window k computed directly from the captured frame
   function automatic int ref_avg(input int k, input int win);
      int acc = 0;
      for (int j = 0; j < win; j++) acc += model_q[k + j];
`ifdef SF_SEQ_ROUND_EN
      return (acc + win / 2) / win;
`else
      return acc / win;
`endif
   endfunction

   // bp_mode: 0 always ready, 1 random ready, 2 five-cycle stall on output 1
   task automatic run_frame(input bit big, input bit gapped, input int bp_mode,
                            input bit pulse_start, input int abort_at);
      int fl, win, n_exp, i, cyc, n_out, we_cnt, last_hs, stall_cnt;
      bit toggle, pulsed, got_done;
      logic [AW-1:0] held_addr;
      fl = big ? FL_D : FL_S;
      win = big ? WIN_D : WIN_S;
      n_exp = fl - win + 1;
      sel = big;
      held_addr = '0;
      @(posedge clk); #1; start = 1'b1;
      @(negedge clk);
      check_eq("idle_busy", m_busy, 0);
      @(posedge clk); #1; start = 1'b0;

      i = 0; cyc = 0; toggle = 1'b0; we_cnt = 0;
      while (i < fl && cyc < 3 * fl + 10) begin
         adc_valid = gapped ? toggle : 1'b1;
         toggle = ~toggle;
         adc_data = DW'(model_q[i]);
         @(negedge clk);
         check_eq("cap_ready", m_adc_ready, 1);
         check_eq("cap_we", m_mem_we, adc_valid);
         if (m_mem_we) begin
            we_cnt++;
            check_eq("cap_addr", m_mem_addr, i);
            check_eq("cap_wdata", m_mem_wdata, model_q[i]);
         end
         if (adc_valid && m_adc_ready) i++;
         @(posedge clk); #1; cyc++;
      end
      adc_valid = 1'b0;
      check_eq("cap_count", i, fl);
      for (int j = 0; j < fl; j++) check_eq("ram_order", big ? d_ram[j] : s_ram[j], model_q[j]);

      n_out = 0; cyc = 0; last_hs = -10; stall_cnt = 0; pulsed = 1'b0; got_done = 1'b0;
      while (!got_done && cyc < 6 * fl + 100) begin
         case (bp_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = !(n_out == 1 && stall_cnt < 5);
         endcase
         adc_valid = 1'($urandom_range(0, 1));
         adc_data = DW'($urandom);
         start = pulse_start && n_out == 2 && !pulsed;
         if (start) pulsed = 1'b1;
         @(negedge clk);
         if (abort_at >= 0 && n_out == abort_at) begin
            rst = 1'b1;
            #1;
            check_eq("abort_valid", m_out_valid, 0);
            check_eq("abort_data", m_out_data, 0);
            check_eq("abort_index", m_out_index, 0);
            check_eq("abort_busy", m_busy, 0);
            check_eq("abort_we", m_mem_we, 0);
            start = 1'b0; adc_valid = 1'b0;
            @(posedge clk); #1; rst = 1'b0;
            return;
         end
         check_eq("run_no_write", m_mem_we, 0);
         if (bp_mode == 2 && m_out_valid && !out_ready && n_out == 1) begin
            check_eq("stall_data", m_out_data, ref_avg(1, win));
            check_eq("stall_index", m_out_index, 1);
            if (stall_cnt > 0) check_eq("stall_addr", m_mem_addr, held_addr);
            held_addr = m_mem_addr;
            stall_cnt++;
         end
         if (m_out_valid && out_ready) begin
            check_eq("out_data", m_out_data, ref_avg(n_out, win));
            check_eq("out_index", m_out_index, n_out);
            n_out++;
            last_hs = cyc;
         end
         if (m_done) begin
            got_done = 1'b1;
            check_eq("done_latency", cyc - last_hs, 1);
            check_eq("out_count", n_out, n_exp);
            check_eq("done_busy", m_busy, 1);
         end
         @(posedge clk); #1; cyc++;
      end
      start = 1'b0; adc_valid = 1'b0;
      check_eq("done_seen", got_done, 1);
      if (bp_mode == 2) check_eq("stall_cycles", stall_cnt, 5);
      @(negedge clk);
      check_eq("done_one_cycle", m_done, 0);
      check_eq("busy_low", m_busy, 0);
      check_eq("we_count", we_cnt, fl);
   endtask

   initial begin
      start = 1'b0; adc_valid = 1'b0; out_ready = 1'b0; adc_data = '0; sel = 1'b0;
      for (int j = 0; j < (1 << AW); j++) begin
         s_ram[j] = '0;
         d_ram[j] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_busy", s_busy, 0);
      check_eq("rst_done", s_done, 0);
      check_eq("rst_adc_ready", s_adc_ready, 0);
      check_eq("rst_we", s_mem_we, 0);
      check_eq("rst_addr", s_mem_addr, 0);
      check_eq("rst_wdata", s_mem_wdata, 0);
      check_eq("rst_out_valid", s_out_valid, 0);
      check_eq("rst_out_data", s_out_data, 0);
      check_eq("rst_out_index", s_out_index, 0);
      check_eq("rst_busy_dflt", d_busy, 0);
      @(posedge clk); #1; rst = 1'b0;

      model_q = {};
      for (int j = 1; j <= FL_S; j++) model_q.push_back(j);
      run_frame(1'b0, 1'b0, 0, 1'b0, -1);
      run_frame(1'b0, 1'b0, 2, 1'b0, -1);
      run_frame(1'b0, 1'b1, 0, 1'b0, -1);
      run_frame(1'b0, 1'b0, 0, 1'b1, -1);

      model_q = {};
      for (int j = 0; j < FL_S; j++) model_q.push_back(int'($urandom_range(0, 255)));
      run_frame(1'b0, 1'b0, 0, 1'b0, 2);
      model_q = {};
      for (int j = 0; j < FL_S; j++) model_q.push_back(10);
      run_frame(1'b0, 1'b0, 0, 1'b0, -1);

      for (int r = 0; r < 6; r++) begin
         model_q = {};
         for (int j = 0; j < FL_S; j++) model_q.push_back(int'($urandom_range(0, 255)));
         run_frame(1'b0, 1'($urandom_range(0, 1)), 1, 1'b0, -1);
      end

      model_q = {};
      for (int j = 0; j < FL_D; j++) model_q.push_back(255);
      run_frame(1'b1, 1'b0, 0, 1'b0, -1);
      model_q = {};
      for (int j = 0; j < FL_D; j++) model_q.push_back(int'($urandom_range(0, 255)));
      run_frame(1'b1, 1'b1, 1, 1'b0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
